// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, valid/ready in and out.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              c_q, c_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic              cmsb_q, cmsb_d;
`endif

    // Two chained half-adder cells plus an OR form the full-adder bit slice.
    logic ha1_s, ha1_c, ha2_s, ha2_c;
    logic bit_s, carry_next;

    always_comb begin
        ha1_s      = a_sh_q[0] ^ b_sh_q[0];
        ha1_c      = a_sh_q[0] & b_sh_q[0];
        ha2_s      = ha1_s ^ c_q;
        ha2_c      = ha1_s & c_q;
        bit_s      = ha2_s;
        carry_next = ha1_c | ha2_c;
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        cmsb_d   = cmsb_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    c_d      = cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_sh_d = {bit_s, sum_sh_q[WIDTH-1:1]};
                c_d      = carry_next;
                if (cnt_q == CNT_LAST) begin
                    // Counter holds at its last value so it never wraps.
                    state_d = DONE;
                    sum_d   = {bit_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = carry_next;
`ifdef SERIAL_ADDER_OVF_EN
                    cmsb_d  = c_q;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q   <= cmsb_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = cmsb_q ^ cout_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder against an arithmetic model.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_vec;
    int n_miscmp;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; result and latency are predicted from plain arithmetic.
    task automatic do_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                         input logic op_cin, input int bp_cycles, input logic early_ready);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] held;
        int               lat;
        int               waited;
        bit               ovf_exp;
        full    = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
        ovf_exp = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (full[WIDTH-1] != op_a[WIDTH-1]);

        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("in_ready_before_op", in_ready, 1);

        in_valid  = 1'b1;
        a         = op_a;
        b         = op_b;
        cin       = op_cin;
        out_ready = early_ready && (bp_cycles == 0);
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin      = $urandom_range(0, 1);

        lat = 0;
        while (!out_valid && lat < 100) begin
            check("in_ready_low_in_run", in_ready, 0);
            tick();
            lat++;
        end
        check("latency", lat, WIDTH);
        check("sum", sum, full[WIDTH-1:0]);
        check("cout", cout, full[WIDTH]);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, ovf_exp);
`endif

        held = sum;
        for (int i = 0; i < bp_cycles; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = 1'b0;
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum_held", sum, full[WIDTH-1:0]);
            check("bp_cout_held", cout, full[WIDTH]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_xfer", out_valid, 0);
        check("in_ready_after_xfer", in_ready, 1);
        check("sum_kept_after_xfer", sum, {56'd0, held});
    endtask

    initial begin
        n_vec     = 0;
        n_miscmp  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        tick();

        do_op(8'h3C, 8'h5A, 1'b0, 0, 1'b1);
        do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 0, 1'b1);
        do_op(8'h12, 8'h34, 1'b0, 5, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 1, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 2, 1'b0);

        // Async reset mid-cycle with non-zero outputs present.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_sum", sum, 0);
        check("async_rst_cout", cout, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Abort an operation part way through RUN.
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'h55;
        cin      = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_valid", out_valid, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            check("aborted_no_out_valid", out_valid, 0);
        end
        do_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder. Consumes the Sum/Carry of two chained half-adder cells (HA) plus an OR gate, one bit per clock, LSB first.
- Operand pair accepted over a valid/ready handshake; result presented over a second valid/ready handshake.
- Sits downstream of the half-adder cell. Used wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result bits.
- cout  out  1  carry-out of MSB.

Behaviour:
- Reset (rst_n low, async): state=IDLE, all shift registers, carry flop, bit counter, sum and cout cleared to 0. out_valid=0, in_ready=1 while in reset.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE. Both are decoded from registered state.
- IDLE: on a clock edge with in_valid&&in_ready:
  - load a_sh<=a, b_sh<=b, c<=cin, cnt<=0, sum_sh<=0;
  - go to RUN.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^c; c <= (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0])), formed by HA1(a_sh[0],b_sh[0]) then HA2(HA1.Sum,c), carry = HA1.Carry|HA2.Carry.
  - a_sh, b_sh shift right by 1; sum_sh shifts right with s entering at MSB.
  - cnt increments.
  - When cnt==WIDTH-1, go to DONE.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. Throughput is one operation per WIDTH+2 cycles minimum.
- DONE: sum=sum_sh and cout=c, held stable while out_valid=1 && out_ready=0 (unlimited backpressure). On an edge with out_ready=1, go to IDLE. sum/cout keep their last value after the handshake.
- In RUN and DONE, in_valid, a, b and cin are ignored. No operand is accepted in the same cycle a result is taken; in_ready rises the cycle after the output handshake.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned and exact.
- cnt width is $clog2(WIDTH); it never wraps within an operation.
- Reset mid-RUN or mid-DONE: the operation is aborted, no out_valid is produced, and the block returns to IDLE with all outputs 0.
- out_ready asserted in IDLE or RUN has no effect.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - extra output port ovf (out, 1) gives signed overflow = (carry into MSB) XOR cout;
  - carry into MSB is captured in a flop on the cnt==WIDTH-1 edge before the final carry update;
  - ovf is valid and held with sum in DONE, and is reset to 0.
- When undefined: port and flop are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> in_ready=1, out_valid=0, sum=0, cout=0 immediately (async).
- WIDTH=8, a=8'h3C, b=8'h5A, cin=0, out_ready=1 -> out_valid high exactly 8 cycles after accept, sum=8'h96, cout=0, in_ready=1 the cycle after the output handshake.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
- Backpressure: a=8'h12, b=8'h34, out_ready=0 for 5 cycles in DONE -> sum=8'h46 held stable, in_ready=0 throughout, in_valid pulses ignored. out_ready=1 -> single transfer.
- Reset mid-op: accept a=8'hAA, b=8'h55, assert rst_n low at cycle 4 of RUN -> no out_valid. Next op a=8'h01, b=8'h01 -> sum=8'h02, cout=0 (no stale carry).
- With SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1. 8'h80+8'h80 -> sum=8'h00, cout=1, ovf=1. 8'hFF+8'h01 -> ovf=0.
